fp_mat_loader: RTL and testbench

Stream-to-matrix buffer that sits directly upstream of the fixed-point matrix multiplier in the attention datapath. Accepts one Q8.8 element per cycle over a valid/ready stream in row-major order and assembles it into a ROWS×COLS register array. Presents the array in parallel, held stable, with its own valid/ready handshake. The multiplier consumes it as one operand.

---
 rtl/fp_attn_pkg.sv | 22 ++
 rtl/fp_mat_bank.sv | 37 +++
 rtl/fp_mat_loader.sv | 172 +++++++++++++++++
 tb/tb_fp_mat_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_attn_pkg.sv
// Shared attention-datapath definitions: Q8.8 element type, matrix geometry and bank states.
// Used by fp_mat_loader, fp_mat_bank and the downstream matrix multiplier.
package fp_attn_pkg;

  localparam int Q_WIDTH   = 16;
  localparam int FRAC_BITS = 8;
  localparam int MAT_ROWS  = 8;
  localparam int MAT_COLS  = 4;

  typedef logic [Q_WIDTH-1:0] q8_8_t;

  typedef enum logic {
    BANK_FILL = 1'b0,
    BANK_FULL = 1'b1
  } bank_st_t;

  // Index width for an n-entry dimension; a 1-entry dimension still gets a 1-bit index.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_mat_bank.sv
// One ROWS x COLS register array, written one element at a time at (row, col).
// Contents reset to zero and are otherwise only changed by a write.
module fp_mat_bank
  import fp_attn_pkg::*;
#(
  parameter int DATA_WIDTH = Q_WIDTH,
  parameter int ROWS       = MAT_ROWS,
  parameter int COLS       = MAT_COLS,
  parameter int RW         = ptr_w(ROWS),
  parameter int CW         = ptr_w(COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [RW-1:0]         i_wr_row,
  input  logic [CW-1:0]         i_wr_col,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_mat [0:ROWS-1][0:COLS-1]
);

  logic [DATA_WIDTH-1:0] r_mem [0:ROWS-1][0:COLS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else if (i_we) begin
      r_mem[i_wr_row][i_wr_col] <= i_wr_data;
    end
  end

  always_comb o_mat = r_mem;

endmodule

// File: rtl/fp_mat_loader.sv
// Stream-to-matrix loader feeding the fixed-point matrix multiplier.
// Define FP_MAT_LOADER_PINGPONG_EN for two banks (fill one while the other is presented).
//
// Bank state | meaning
// BANK_FILL  | bank accepts stream elements at the write pointer
// BANK_FULL  | bank holds a complete matrix, presented or waiting to be presented
module fp_mat_loader
  import fp_attn_pkg::*;
#(
  parameter int DATA_WIDTH = Q_WIDTH,
  parameter int ROWS       = MAT_ROWS,
  parameter int COLS       = MAT_COLS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] mat_out [0:ROWS-1][0:COLS-1],
  output logic                  mat_valid,
  input  logic                  mat_ready,
  output logic                  err_len
);

  localparam int RW = ptr_w(ROWS);
  localparam int CW = ptr_w(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_in_ready;
  logic          r_mat_valid;
  logic          r_err;

  logic w_accept, w_release, w_at_end, w_complete, w_err;

  assign w_accept   = in_valid & r_in_ready;
  assign w_release  = r_mat_valid & mat_ready;
  assign w_at_end   = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_complete = w_accept & w_at_end;
  // Early in_last drops the partial matrix; a missing in_last still completes it.
  assign w_err      = w_accept & (in_last ^ w_at_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_accept) begin
        if (w_at_end || in_last) begin
          r_row <= '0;
          r_col <= '0;
        end else if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

`ifdef FP_MAT_LOADER_PINGPONG_EN
  bank_st_t r_st [0:1];
  bank_st_t w_st_nxt [0:1];
  logic     r_wr_sel, r_rd_sel, w_wr_sel_nxt, w_rd_sel_nxt;
  logic [DATA_WIDTH-1:0] w_mat0 [0:ROWS-1][0:COLS-1];
  logic [DATA_WIDTH-1:0] w_mat1 [0:ROWS-1][0:COLS-1];

  // Banks strictly alternate, so toggling both selects preserves completion order.
  always_comb begin
    w_st_nxt     = r_st;
    w_wr_sel_nxt = r_wr_sel;
    w_rd_sel_nxt = r_rd_sel;
    if (w_complete) begin
      w_st_nxt[r_wr_sel] = BANK_FULL;
      w_wr_sel_nxt       = ~r_wr_sel;
    end
    if (w_release) begin
      w_st_nxt[r_rd_sel] = BANK_FILL;
      w_rd_sel_nxt       = ~r_rd_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st[0]     <= BANK_FILL;
      r_st[1]     <= BANK_FILL;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_mat_valid <= 1'b0;
    end else begin
      r_st        <= w_st_nxt;
      r_wr_sel    <= w_wr_sel_nxt;
      r_rd_sel    <= w_rd_sel_nxt;
      r_in_ready  <= !((w_st_nxt[0] == BANK_FULL) && (w_st_nxt[1] == BANK_FULL));
      r_mat_valid <= (w_st_nxt[w_rd_sel_nxt] == BANK_FULL);
    end
  end

  fp_mat_bank #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_accept & ~r_wr_sel),
    .i_wr_row  (r_row),
    .i_wr_col  (r_col),
    .i_wr_data (in_data),
    .o_mat     (w_mat0)
  );

  fp_mat_bank #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_bank1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_accept & r_wr_sel),
    .i_wr_row  (r_row),
    .i_wr_col  (r_col),
    .i_wr_data (in_data),
    .o_mat     (w_mat1)
  );

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        mat_out[r][c] = r_rd_sel ? w_mat1[r][c] : w_mat0[r][c];
      end
    end
  end
`else
  bank_st_t r_st, w_st_nxt;

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      BANK_FILL: if (w_complete) w_st_nxt = BANK_FULL;
      BANK_FULL: if (w_release)  w_st_nxt = BANK_FILL;
      default:   w_st_nxt = BANK_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st        <= BANK_FILL;
      r_in_ready  <= 1'b1;
      r_mat_valid <= 1'b0;
    end else begin
      r_st        <= w_st_nxt;
      r_in_ready  <= (w_st_nxt == BANK_FILL);
      r_mat_valid <= (w_st_nxt == BANK_FULL);
    end
  end

  fp_mat_bank #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_accept),
    .i_wr_row  (r_row),
    .i_wr_col  (r_col),
    .i_wr_data (in_data),
    .o_mat     (mat_out)
  );
`endif

  assign in_ready  = r_in_ready;
  assign mat_valid = r_mat_valid;
  assign err_len   = r_err;

endmodule

// File: tb/tb_fp_mat_loader.sv
// Scoreboard bench for fp_mat_loader (8x4 Q8.8); expected matrices are queued as they are sent.
module tb_fp_mat_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, mat_ready;
  logic [15:0] in_data;
  logic        in_ready, mat_valid, err_len;
  logic [15:0] mat_out [0:7][0:3];

  int n_vec = 0, n_bad = 0, err_cnt = 0, stall_cnt = 0;
  bit stream_chk = 1'b0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  fp_mat_loader #(.DATA_WIDTH(16), .ROWS(8), .COLS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mat_out   (mat_out),
    .mat_valid (mat_valid),
    .mat_ready (mat_ready),
    .err_len   (err_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Release happens on the posedge after a negedge that sees mat_valid && mat_ready.
  always @(negedge clk) begin
    if (rst_n && err_len) err_cnt++;
    if (rst_n && stream_chk && in_valid && !in_ready) stall_cnt++;
    if (rst_n && mat_valid && mat_ready) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
          else chk($sformatf("mat[%0d][%0d]", r, c), {16'h0, mat_out[r][c]}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input bit last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_mat(input logic [15:0] base);
    for (int i = 0; i < 32; i++) exp_q.push_back(base + 16'(i));
  endtask

  task automatic send_mat(input logic [15:0] base, input bit with_last);
    for (int i = 0; i < 32; i++) send(base + 16'(i), with_last && (i == 31));
  endtask

  task automatic take();
    int t = 0;
    mat_ready = 1'b1;
    @(negedge clk);
    while (!mat_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!mat_valid) chk("take_timeout", 32'd0, 32'd1);
    tick();
    mat_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; mat_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mat_valid", mat_valid, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_mat00", mat_out[0][0], 0);
    chk("rst_mat73", mat_out[7][3], 0);
    tick();
    rst_n = 1'b1;
    tick();

    // First matrix 0x0001..0x0020, boundary latency around the final accept
    push_mat(16'h0001);
    for (int i = 0; i < 31; i++) send(16'(i + 1), 1'b0);
    chk("mv_before_last", mat_valid, 0);
    send(16'h0020, 1'b1);
    chk("mv_latency", mat_valid, 1);
    chk("t1_mat00", mat_out[0][0], 16'h0001);
    chk("t1_mat10", mat_out[1][0], 16'h0005);
    chk("t1_mat73", mat_out[7][3], 16'h0020);

`ifdef FP_MAT_LOADER_PINGPONG_EN
    push_mat(16'h0021);
    send_mat(16'h0021, 1'b1);
    chk("pp_in_ready_full", in_ready, 0);
    chk("pp_hold_mat00", mat_out[0][0], 16'h0001);
    chk("pp_hold_mat73", mat_out[7][3], 16'h0020);
    take();
    chk("pp_next_valid", mat_valid, 1);
    take();
`else
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_in_ready", in_ready, 0);
      chk("hold_mat10", mat_out[1][0], 16'h0005);
    end
    take();
    chk("rel_in_ready", in_ready, 1);
`endif
    chk("rel_mat_valid", mat_valid, 0);
    chk("t1_no_err", err_cnt, 0);

    // Early in_last on the 5th element
    for (int i = 1; i <= 4; i++) send(16'(i), 1'b0);
    send(16'h0005, 1'b1);
    chk("err_short", err_len, 1);
    tick();
    chk("err_pulse_len", err_len, 0);
    chk("short_no_valid", mat_valid, 0);
    push_mat(16'h0100);
    send_mat(16'h0100, 1'b1);
    chk("after_short_valid", mat_valid, 1);
    chk("after_short_mat00", mat_out[0][0], 16'h0100);
    take();

    // Final position without in_last
    push_mat(16'h0200);
    send_mat(16'h0200, 1'b0);
    chk("err_nolast", err_len, 1);
    chk("nolast_valid", mat_valid, 1);
    chk("nolast_mat73", mat_out[7][3], 16'h021F);
    take();
    chk("err_count", err_cnt, 2);

    // Continuous consumer, back-to-back matrices
    mat_ready  = 1'b1;
    stall_cnt  = 0;
    stream_chk = 1'b1;
    for (int m = 0; m < 3; m++) push_mat(16'h0500 + 16'(m * 32));
    for (int m = 0; m < 3; m++) send_mat(16'h0500 + 16'(m * 32), 1'b1);
    stream_chk = 1'b0;
    repeat (3) tick();
    mat_ready = 1'b0;
`ifdef FP_MAT_LOADER_PINGPONG_EN
    chk("stream_no_stall", stall_cnt, 0);
`else
    chk("stream_bubble", (stall_cnt >= 1) ? 32'd1 : 32'd0, 32'd1);
`endif
    chk("stream_drained", exp_q.size(), 0);

    // Reset after 17 accepts; stale matrix from the last release must clear
    for (int i = 0; i < 17; i++) send(16'h0300 + 16'(i), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_mat_valid", mat_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("mid_rst_mat[%0d][%0d]", r, c), mat_out[r][c], 0);
    tick();
    rst_n = 1'b1;
    tick();
    push_mat(16'h0400);
    send_mat(16'h0400, 1'b1);
    chk("post_rst_mat00", mat_out[0][0], 16'h0400);
    take();
    chk("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
